// File: rtl/sys_ctrl_multi.sv
// System control block on the IOC register bus.
// Holds the read-only ID registers, sticky error capture with a mask and an
// interrupt, a scratch register, and N soft-reset channels with fixed-length
// pulses. A power-on reset sequence runs on every channel.

// One soft-reset channel: a down-counter that is loaded by a trigger, with a
// registered busy flag.
module sys_ctrl_rst_ch #(
   parameter int RST_CYCLES = 16
) (
   input  logic i_sys_clk,
   input  logic i_reset,
   input  logic i_trig,
   output logic o_busy
);
   localparam logic [7:0] RST_LD = 8'(RST_CYCLES);

   logic [7:0] cnt_q, cnt_d;
   logic       busy_q;

   // A trigger reloads the full length, so a retrigger extends the pulse.
   // Otherwise the counter runs down and stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (i_trig)
         cnt_d = RST_LD;
      else if (cnt_q != 8'd0)
         cnt_d = cnt_q - 8'd1;
   end

   // The busy flag is decoded from the next count and then registered, so it
   // tracks cnt_q != 0 with no combinational glitches.
   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         cnt_q  <= RST_LD;
         busy_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= (cnt_d != 8'd0);
      end
   end

   assign o_busy = busy_q;
endmodule

module sys_ctrl_multi #(
   parameter logic [7:0] MODULE_VER = 8'h02,
   parameter logic [7:0] SYSTEM_VER = 8'h01,
   parameter logic [7:0] MANU_ID    = 8'h01,
   parameter int         N_RST_CH   = 4,
   parameter int         RST_CYCLES = 16,
   parameter int         N_ERR      = 8
) (
   input  logic                i_sys_clk,
   input  logic                i_reset,
   input  logic                i_cs,
   input  logic [4:0]          i_ioc,
   input  logic [7:0]          i_data_in,
   input  logic                i_load_cmd,
   input  logic                i_fetch_cmd,
   output logic [7:0]          o_data_out,
   input  logic [N_ERR-1:0]    i_error_list,
   output logic                o_error_irq,
   output logic [N_RST_CH-1:0] o_soft_reset
);
   logic                wr_en, rd_en;
   logic [N_ERR-1:0]    sticky_q, sticky_d, mask_q, mask_d, clr;
   logic [7:0]          scratch_q, scratch_d, dout_q, dout_d, rdata;
   logic [7:0]          sticky8, mask8, busy8;
   logic                irq_q;
   logic [N_RST_CH-1:0] trig;

   // A write takes priority over a read. A fetch in the same cycle as a load
   // is dropped.
   assign wr_en = i_cs & i_load_cmd;
   assign rd_en = i_cs & i_fetch_cmd & ~i_load_cmd;

   // Decode the trigger and W1C strobes. Data bits above the channel or error
   // count are ignored.
   always_comb begin
      trig = '0;
      clr  = '0;
      if (wr_en && i_ioc == 5'd4) trig = i_data_in[N_RST_CH-1:0];
      if (wr_en && i_ioc == 5'd5) clr  = i_data_in[N_ERR-1:0];
   end

   genvar c;
   generate
      for (c = 0; c < N_RST_CH; c++) begin : g_ch
         sys_ctrl_rst_ch #(.RST_CYCLES(RST_CYCLES)) u_ch (
            .i_sys_clk (i_sys_clk),
            .i_reset   (i_reset),
            .i_trig    (trig[c]),
            .o_busy    (o_soft_reset[c])
         );
      end
   endgenerate

   // Zero-extend the narrow registers to the 8-bit bus width.
   always_comb begin
      sticky8 = '0;
      mask8   = '0;
      busy8   = '0;
      sticky8[N_ERR-1:0]    = sticky_q;
      mask8[N_ERR-1:0]      = mask_q;
      busy8[N_RST_CH-1:0]   = o_soft_reset;
   end

   // The read mux shows register values from before any update in the same
   // cycle.
   always_comb begin
      rdata = 8'h00;
      case (i_ioc)
         5'd0: rdata = MODULE_VER;
         5'd1: rdata = SYSTEM_VER;
         5'd2: rdata = MANU_ID;
         5'd3: rdata = sticky8;
         5'd6: rdata = mask8;
         5'd7: rdata = scratch_q;
         5'd8: rdata = busy8;
         default: rdata = 8'h00;
      endcase
   end

   // Next-state logic for the register file. An error that is set in the
   // same cycle as a clear wins over the clear.
   always_comb begin
      sticky_d  = (sticky_q & ~clr) | i_error_list;
      mask_d    = mask_q;
      scratch_d = scratch_q;
      dout_d    = dout_q;
      if (wr_en && i_ioc == 5'd6) mask_d    = i_data_in[N_ERR-1:0];
      if (wr_en && i_ioc == 5'd7) scratch_d = i_data_in;
      if (rd_en)                  dout_d    = rdata;
   end

   // Register state. Only i_reset clears it; the soft resets do not. The
   // interrupt follows the sticky and mask registers one cycle later.
   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         sticky_q  <= '0;
         mask_q    <= '1;
         scratch_q <= 8'h00;
         dout_q    <= 8'h00;
         irq_q     <= 1'b0;
      end else begin
         sticky_q  <= sticky_d;
         mask_q    <= mask_d;
         scratch_q <= scratch_d;
         dout_q    <= dout_d;
         irq_q     <= |(sticky_q & ~mask_q);
      end
   end

   assign o_data_out  = dout_q;
   assign o_error_irq = irq_q;
endmodule
